cache_req_master: RTL and testbench
===================================

# cache_req_master

CPU-side request initiator for `dm_cache_controller`. It takes a queue of read/write commands and issues each one on the cache CPU port as a single-cycle valid pulse, then waits for `cpu_data_ready`. It checks read data against an expected value and keeps done, error and timeout status. It replaces hand-written bench tasks and serves as the traffic source in on-FPGA cache soak tests.

## Interface
- `FIFO_DEPTH`, default 4: command queue depth; power of two, at least 2.
- `GAP_CYCLES`, default 2: idle cycles inserted after each completed request; 0 is legal.
- `TIMEOUT`, default 1000: maximum number of WAIT cycles before a request is abandoned; at least 1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid_i`, input, 1: a command is offered.
- `cmd_ready_o`, output, 1: the queue is not full.
- `cmd_rw_i`, input, 1: 1 selects write, 0 selects read.
- `cmd_addr_i`, input, 32: byte address.
- `cmd_data_i`, input, 32: write data for writes; expected data for reads.
- `cmd_check_i`, input, 1: compare read data against `cmd_data_i`; ignored for writes.
- `cpu_req_valid_o`, output, 1: request strobe to the cache.
- `cpu_req_rw_o`, output, 1: request direction.
- `cpu_req_addr_o`, output, 32: request address.
- `cpu_req_data_o`, output, 32: request write data.
- `cpu_data_ready_i`, input, 1: cache completion.
- `cpu_data_i`, input, 32: cache read data.
- `rsp_valid_o`, output, 1: one-cycle completion pulse.
- `rsp_data_o`, output, 32: captured `cpu_data_i`; 0 for timeouts.
- `rsp_err_o`, output, 1: mismatch or timeout on this response.
- `busy_o`, output, 1: high when the FSM is not in IDLE or the queue is non-empty.
- `done_cnt_o`, output, 16: completed requests; saturates at 0xFFFF.
- `err_cnt_o`, output, 16: responses with `rsp_err_o=1`; saturates at 0xFFFF.
- `timeout_o`, output, 1: sticky; set by the first timeout, cleared only by `rst`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and GAP.
- **IDLE**
  - If the queue is non-empty, pop its head into the request registers and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `cpu_req_valid_o=1`; rw, addr and data are driven from the registers.
  - Clear the wait counter, then go to WAIT.
- **WAIT**
  - `cpu_req_valid_o=0`; `cpu_req_rw_o`, `cpu_req_addr_o` and `cpu_req_data_o` hold their values.
  - On a cycle with `cpu_data_ready_i=1`:
    - capture `cpu_data_i`;
    - error = read AND check AND (`cpu_data_i` != expected);
    - go to GAP, or to IDLE when `GAP_CYCLES=0`.
  - Otherwise increment the wait counter.
  - When the counter reaches `TIMEOUT-1` with ready still low:
    - timeout response: error=1, data 0;
    - set `timeout_o`;
    - go to GAP/IDLE.
- **GAP**: count `GAP_CYCLES` cycles, then go to IDLE.
- `cpu_data_ready_i` is sampled only in WAIT. Ready seen in IDLE, ISSUE or GAP is ignored.
- A completed request increments `done_cnt_o`, including timeouts. An errored response also increments `err_cnt_o`.
- The queue accepts a command on a cycle where `cmd_valid_i & cmd_ready_o`. Push and pop in the same cycle are allowed. Occupancy is unchanged in that case.
- **Reset** (asynchronous, takes effect mid-transaction)
  - FSM returns to IDLE and the queue empties.
  - All outputs go to 0 immediately: `cpu_req_*`, `rsp_*`, the counters, `busy_o` and `timeout_o`.
  - `cmd_ready_o` goes to 1.
  - An outstanding cache request is dropped; its later ready is ignored.

## Timing
- Command accepted at edge N → earliest `cpu_req_valid_o` is in cycle N+2: one cycle to pop, one to issue.
- `cpu_req_valid_o` is high for exactly one cycle per command.
- Ready sampled high at edge M → `rsp_valid_o` is high for the cycle after M. `rsp_data_o`/`rsp_err_o` are valid with it and hold until the next response.
- Counters update at the same edge that raises `rsp_valid_o`.
- Back-to-back commands: consecutive valid pulses are separated by at least 1 (WAIT) + `GAP_CYCLES` + 1 (IDLE) idle cycles.
- Timeout: `rsp_valid_o` rises exactly `TIMEOUT` cycles after the ISSUE cycle.
- `cmd_ready_o` = !full, registered. A pop on the same edge as a full condition re-opens `cmd_ready_o` in the next cycle.

## Structure
- `cache_defs.vh` (shared with `dm_cache_controller`) holds:
  - the CPU address/data widths (32);
  - the FSM state encodings `ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_GAP`;
  - the command field width (66 = rw + check + addr + data).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - registered full/empty;
  - asynchronous active-high reset;
  - instantiated once with a 66-bit width.

## Test plan
- **Write then read:** push write 0x4000←0xABCD, then read 0x4000 check=1 exp 0xABCD against `dm_cache_controller` → 2 responses, `rsp_data_o`=0xABCD, `done_cnt_o`=2, `err_cnt_o`=0.
- **Mismatch:** read 0x4 check=1 with expected value = actual+1 → `rsp_err_o=1`, `err_cnt_o`=1, `timeout_o`=0. The same read with check=0 gives no error.
- **Timeout:** tie `cpu_data_ready_i`=0, `TIMEOUT`=16, issue a read → `rsp_valid_o` 16 cycles after the valid pulse with err=1 and data 0; `timeout_o` stays 1 afterwards.
- **Queue full:** `FIFO_DEPTH`=4, ready held low, push 6 commands → `cmd_ready_o`=0 after 5 accepted (1 in flight + 4 queued). All 5 complete in order once ready returns.
- **Spacing:** `GAP_CYCLES`=2, ready returned 1 cycle after each valid → valid pulses exactly 5 cycles apart.
- **Reset mid-transaction:** assert `rst` during WAIT with 2 commands queued → all outputs 0 within the same cycle. A late `cpu_data_ready_i` pulse after reset produces no response; `done_cnt_o` stays 0.

Source files
------------

// File: rtl/cache_req_master_pkg.sv
// Shared definitions for the cache request master.
// Contents:
//   CpuAddrW / CpuDataW - CPU-port address and data widths (32)
//   CmdW                - packed command width: rw + check + addr + data (66)
//   state_e             - request FSM states (idle, issue, wait, gap)
//   cmd_t               - packed queued-command layout
//   sat_inc16           - saturating 16-bit increment for status counters
package cache_req_master_pkg;

    localparam int unsigned CpuAddrW = 32;
    localparam int unsigned CpuDataW = 32;
    localparam int unsigned CmdW     = 2 + CpuAddrW + CpuDataW;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StGap   = 2'd3
    } state_e;

    typedef struct packed {
        logic                rw;     // 1 = write
        logic                check;  // compare read data against data
        logic [CpuAddrW-1:0] addr;
        logic [CpuDataW-1:0] data;   // write data, or expected read data
    } cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_req_master_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   wr_en_i, wr_data_i  - push request and data (ignored while full)
//   rd_en_i, rd_data_o  - pop request (ignored while empty), head entry
//   full_o, empty_o     - registered occupancy flags
module cache_req_master_sync_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);
    localparam logic [AddrW:0]   CntOne   = (AddrW + 1)'(1);
    localparam logic [AddrW:0]   CntDepth = (AddrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic             push, pop;

    assign push = wr_en_i & ~full_q;
    assign pop  = rd_en_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
            full_q  <= (count_d == CntDepth);
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read behind the empty flag.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/cache_req_master.sv
// CPU-side request initiator for the direct-mapped cache controller.
// Queues read/write commands, issues each as a one-cycle valid pulse on the
// cache CPU port, waits for completion (or times out), checks read data and
// keeps done/error/timeout status.
// Parameters: FIFO_DEPTH (queue depth), GAP_CYCLES (idle cycles after each
//             response), TIMEOUT (WAIT-cycle budget, >= 1).
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o         - command handshake (ready = queue not full)
//   cmd_rw_i, cmd_addr_i, cmd_data_i, cmd_check_i - command fields
//   cpu_req_valid_o/rw_o/addr_o/data_o - request to the cache
//   cpu_data_ready_i, cpu_data_i    - cache completion and read data
//   rsp_valid_o, rsp_data_o, rsp_err_o - one-cycle response pulse and payload
//   busy_o                          - FSM active or queue non-empty
//   done_cnt_o, err_cnt_o           - saturating completion / error counters
//   timeout_o                       - sticky timeout flag
module cache_req_master
    import cache_req_master_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_rw_i,
    input  logic [CpuAddrW-1:0] cmd_addr_i,
    input  logic [CpuDataW-1:0] cmd_data_i,
    input  logic                cmd_check_i,
    output logic                cpu_req_valid_o,
    output logic                cpu_req_rw_o,
    output logic [CpuAddrW-1:0] cpu_req_addr_o,
    output logic [CpuDataW-1:0] cpu_req_data_o,
    input  logic                cpu_data_ready_i,
    input  logic [CpuDataW-1:0] cpu_data_i,
    output logic                rsp_valid_o,
    output logic [CpuDataW-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic [15:0]         done_cnt_o,
    output logic [15:0]         err_cnt_o,
    output logic                timeout_o
);

    // The response pulse follows the deciding WAIT edge by one cycle, so the
    // timeout decision is made on the WAIT cycle whose count is TIMEOUT-2.
    // That lands rsp_valid_o exactly TIMEOUT cycles after the ISSUE cycle.
    localparam logic [31:0] WaitLast = (TIMEOUT > 1) ? 32'(TIMEOUT - 2) : 32'd0;
    localparam logic [31:0] GapLast  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam bit          HasGap   = (GAP_CYCLES != 0);

    cmd_t            push_cmd, head_cmd;
    logic [CmdW-1:0] head_raw;
    logic            fifo_full, fifo_empty, pop;

    state_e          state_q, state_d;
    cmd_t            req_q, req_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]     gap_cnt_q, gap_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [CpuDataW-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     done_cnt_q, done_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            timeout_q, timeout_d;
    logic            complete;

    always_comb begin
        push_cmd.rw    = cmd_rw_i;
        push_cmd.check = cmd_check_i;
        push_cmd.addr  = cmd_addr_i;
        push_cmd.data  = cmd_data_i;
    end

    assign head_cmd = cmd_t'(head_raw);

    cache_req_master_sync_fifo #(
        .WIDTH (CmdW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cmd_valid_i),
        .wr_data_i (push_cmd),
        .rd_en_i   (pop),
        .rd_data_o (head_raw),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        done_cnt_d  = done_cnt_q;
        err_cnt_d   = err_cnt_q;
        timeout_d   = timeout_q;
        pop         = 1'b0;
        complete    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    req_d   = head_cmd;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Ready wins over a timeout landing on the same cycle.
                if (cpu_data_ready_i) begin
                    complete   = 1'b1;
                    rsp_data_d = cpu_data_i;
                    rsp_err_d  = !req_q.rw && req_q.check && (cpu_data_i != req_q.data);
                end else if (wait_cnt_q >= WaitLast) begin
                    complete   = 1'b1;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
                if (complete) begin
                    rsp_valid_d = 1'b1;
                    done_cnt_d  = sat_inc16(done_cnt_q);
                    if (rsp_err_d) err_cnt_d = sat_inc16(err_cnt_q);
                    gap_cnt_d   = '0;
                    state_d     = HasGap ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q >= GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= '0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            done_cnt_q  <= done_cnt_d;
            err_cnt_q   <= err_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Request fields come straight from req_q, so they hold through WAIT.
    assign cpu_req_valid_o = (state_q == StIssue);
    assign cpu_req_rw_o    = req_q.rw;
    assign cpu_req_addr_o  = req_q.addr;
    assign cpu_req_data_o  = req_q.data;

    assign cmd_ready_o = ~fifo_full;
    assign busy_o      = (state_q != StIdle) || !fifo_empty;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign done_cnt_o  = done_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cache_req_master.sv
// Directed self-checking bench for cache_req_master (FIFO_DEPTH=4,
// GAP_CYCLES=2, TIMEOUT=16). A small associative memory stands in for the
// cache when serving requests.
module tb_cache_req_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_rw_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        cmd_check_i = 1'b0;
    logic        cpu_req_valid_o;
    logic        cpu_req_rw_o;
    logic [31:0] cpu_req_addr_o;
    logic [31:0] cpu_req_data_o;
    logic        cpu_data_ready_i = 1'b0;
    logic [31:0] cpu_data_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [15:0] done_cnt_o;
    logic [15:0] err_cnt_o;
    logic        timeout_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [31:0] mem [logic [31:0]];

    cache_req_master #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (2),
        .TIMEOUT    (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_rw_i         (cmd_rw_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_data_i       (cmd_data_i),
        .cmd_check_i      (cmd_check_i),
        .cpu_req_valid_o  (cpu_req_valid_o),
        .cpu_req_rw_o     (cpu_req_rw_o),
        .cpu_req_addr_o   (cpu_req_addr_o),
        .cpu_req_data_o   (cpu_req_data_o),
        .cpu_data_ready_i (cpu_data_ready_i),
        .cpu_data_i       (cpu_data_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_err_o        (rsp_err_o),
        .busy_o           (busy_o),
        .done_cnt_o       (done_cnt_o),
        .err_cnt_o        (err_cnt_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1, "bench watchdog expired");
    end

    // Offer one command for one cycle (assumes the queue has room).
    task automatic push(input logic rw, input logic chk, input logic [31:0] a,
                        input logic [31:0] d, output int pcyc);
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_rw_i    = rw;
        cmd_check_i = chk;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        pcyc        = cyc;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Wait for a valid pulse, answer with ready during the first WAIT cycle,
    // then sample the response in the following cycle.
    task automatic serve(input int limit, output bit ok, output int vcyc,
                         output logic vrw, output logic [31:0] vaddr, output logic [31:0] vdata,
                         output logic rv, output logic [31:0] rd, output logic re);
        ok = 1'b0; vcyc = 0; vrw = 1'b0; vaddr = '0; vdata = '0; rv = 1'b0; rd = '0; re = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cpu_req_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            vcyc  = cyc;
            vrw   = cpu_req_rw_o;
            vaddr = cpu_req_addr_o;
            vdata = cpu_req_data_o;
            @(negedge clk);
            cpu_data_ready_i = 1'b1;
            if (vrw) begin
                mem[vaddr] = vdata;
                cpu_data_i = '0;
            end else begin
                cpu_data_i = mem.exists(vaddr) ? mem[vaddr] : 32'h0;
            end
            @(negedge clk);
            cpu_data_ready_i = 1'b0;
            cpu_data_i       = '0;
            rv = rsp_valid_o;
            rd = rsp_data_o;
            re = rsp_err_o;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (cmd_ready_o !== 1'b1)
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({cpu_req_valid_o, cpu_req_rw_o, cpu_req_addr_o, cpu_req_data_o, rsp_valid_o,
             rsp_data_o, rsp_err_o, busy_o, done_cnt_o, err_cnt_o, timeout_o} !== '0)
            $display("FAIL reset_outputs: valid=%b addr=%h rsp=%b busy=%b done=%0d err=%0d to=%b want all 0",
                     cpu_req_valid_o, cpu_req_addr_o, rsp_valid_o, busy_o, done_cnt_o, err_cnt_o, timeout_o);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        int p0, p1, vc;
        bit ok;
        logic vrw, rv, re;
        logic [31:0] va, vd, rd;
        push(1'b1, 1'b0, 32'h4000, 32'hABCD, p0);
        push(1'b0, 1'b1, 32'h4000, 32'hABCD, p1);
        serve(10, ok, vc, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if (!ok || vc != p0 + 2)
            $display("FAIL wr_latency: ok=%b valid cycle %0d want %0d", ok, vc, p0 + 2);
        else pass_cnt++;
        total_cnt++;
        if ({vrw, va, vd} !== {1'b1, 32'h4000, 32'hABCD})
            $display("FAIL wr_req_fields: rw=%b addr=%h data=%h want 1 4000 abcd", vrw, va, vd);
        else pass_cnt++;
        total_cnt++;
        if ({rv, re} !== 2'b10)
            $display("FAIL wr_rsp: valid=%b err=%b want 1 0", rv, re);
        else pass_cnt++;
        serve(10, ok, vc, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if ({ok, rv, rd, re} !== {1'b1, 1'b1, 32'hABCD, 1'b0})
            $display("FAIL rd_rsp: ok=%b valid=%b data=%h err=%b want 1 1 abcd 0", ok, rv, rd, re);
        else pass_cnt++;
        total_cnt++;
        if ({done_cnt_o, err_cnt_o} !== {16'd2, 16'd0})
            $display("FAIL wr_rd_counts: done=%0d err=%0d want 2 0", done_cnt_o, err_cnt_o);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({busy_o, rsp_valid_o, rsp_data_o} !== {1'b0, 1'b0, 32'hABCD})
            $display("FAIL idle_hold: busy=%b rsp_valid=%b data=%h want 0 0 abcd",
                     busy_o, rsp_valid_o, rsp_data_o);
        else pass_cnt++;
    endtask

    task automatic test_mismatch();
        int p, vc;
        bit ok;
        logic vrw, rv, re;
        logic [31:0] va, vd, rd;
        push(1'b0, 1'b1, 32'h4, 32'h1235, p);
        serve(10, ok, vc, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if ({ok, rv, rd, re} !== {1'b1, 1'b1, 32'h1234, 1'b1})
            $display("FAIL mismatch_rsp: ok=%b valid=%b data=%h err=%b want 1 1 1234 1", ok, rv, rd, re);
        else pass_cnt++;
        total_cnt++;
        if ({done_cnt_o, err_cnt_o, timeout_o} !== {16'd3, 16'd1, 1'b0})
            $display("FAIL mismatch_counts: done=%0d err=%0d to=%b want 3 1 0",
                     done_cnt_o, err_cnt_o, timeout_o);
        else pass_cnt++;
        push(1'b0, 1'b0, 32'h4, 32'h1235, p);
        serve(10, ok, vc, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if ({ok, rv, rd, re, err_cnt_o, done_cnt_o} !== {1'b1, 1'b1, 32'h1234, 1'b0, 16'd1, 16'd4})
            $display("FAIL nocheck_rsp: valid=%b data=%h err=%b errcnt=%0d done=%0d want 1 1234 0 1 4",
                     rv, rd, re, err_cnt_o, done_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int p, vc, rc;
        bit seen_v, seen_r, ok;
        logic vrw, rv, re;
        logic [31:0] va, vd, rd;
        vc = 0; rc = 0; seen_v = 1'b0; seen_r = 1'b0;
        cpu_data_i = 32'h5555_5555;  // must not leak into a timeout response
        push(1'b0, 1'b1, 32'h8, 32'h0, p);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_req_valid_o) begin
                seen_v = 1'b1;
                vc     = cyc;
                break;
            end
        end
        if (seen_v) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (rsp_valid_o) begin
                    seen_r = 1'b1;
                    rc     = cyc;
                    break;
                end
            end
        end
        total_cnt++;
        if (!seen_r || rc - vc != 16)
            $display("FAIL timeout_latency: seen=%b latency %0d want 16", seen_r, rc - vc);
        else pass_cnt++;
        total_cnt++;
        if ({rsp_err_o, rsp_data_o, timeout_o} !== {1'b1, 32'h0, 1'b1})
            $display("FAIL timeout_rsp: err=%b data=%h to=%b want 1 0 1", rsp_err_o, rsp_data_o, timeout_o);
        else pass_cnt++;
        total_cnt++;
        if ({done_cnt_o, err_cnt_o} !== {16'd5, 16'd2})
            $display("FAIL timeout_counts: done=%0d err=%0d want 5 2", done_cnt_o, err_cnt_o);
        else pass_cnt++;
        cpu_data_i = '0;
        push(1'b0, 1'b1, 32'h4000, 32'hABCD, p);
        serve(12, ok, vc, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if ({ok, rv, re, timeout_o, done_cnt_o, err_cnt_o} !== {1'b1, 1'b1, 1'b0, 1'b1, 16'd6, 16'd2})
            $display("FAIL timeout_sticky: valid=%b err=%b to=%b done=%0d err=%0d want 1 0 1 6 2",
                     rv, re, timeout_o, done_cnt_o, err_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_queue_full();
        int accepted, vc;
        bit ok;
        logic vrw, rv, re;
        logic [31:0] va, vd, rd;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                cmd_valid_i = 1'b1;
                cmd_rw_i    = 1'b1;
                cmd_check_i = 1'b0;
                cmd_addr_i  = 32'h100 + 32'(4 * i);
                cmd_data_i  = 32'(i + 1);
                accepted++;
            end else begin
                cmd_valid_i = 1'b0;
                break;
            end
        end
        cmd_valid_i = 1'b0;
        total_cnt++;
        if (accepted != 5 || cmd_ready_o !== 1'b0)
            $display("FAIL queue_full: accepted %0d ready=%b want 5 0", accepted, cmd_ready_o);
        else pass_cnt++;
        total_cnt++;
        if ({cpu_req_valid_o, cpu_req_addr_o, cpu_req_data_o} !== {1'b0, 32'h100, 32'h1})
            $display("FAIL wait_hold: valid=%b addr=%h data=%h want 0 100 1",
                     cpu_req_valid_o, cpu_req_addr_o, cpu_req_data_o);
        else pass_cnt++;
        cpu_data_ready_i = 1'b1;
        @(negedge clk);
        cpu_data_ready_i = 1'b0;
        total_cnt++;
        if ({rsp_valid_o, rsp_err_o} !== 2'b10)
            $display("FAIL inflight_rsp: valid=%b err=%b want 1 0", rsp_valid_o, rsp_err_o);
        else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            serve(12, ok, vc, vrw, va, vd, rv, rd, re);
            total_cnt++;
            if ({ok, va, vd, rv} !== {1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b1})
                $display("FAIL queue_order_%0d: ok=%b addr=%h data=%h rsp=%b want 1 %h %h 1",
                         i, ok, va, vd, rv, 32'h100 + 32'(4 * i), i + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if ({cmd_ready_o, done_cnt_o, timeout_o} !== {1'b1, 16'd11, 1'b1})
            $display("FAIL queue_drain: ready=%b done=%0d to=%b want 1 11 1",
                     cmd_ready_o, done_cnt_o, timeout_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int p, v0, v1;
        bit ok0, ok1;
        logic vrw, rv, re;
        logic [31:0] va, vd, rd;
        push(1'b1, 1'b0, 32'h200, 32'h1, p);
        push(1'b1, 1'b0, 32'h204, 32'h2, p);
        serve(10, ok0, v0, vrw, va, vd, rv, rd, re);
        serve(10, ok1, v1, vrw, va, vd, rv, rd, re);
        total_cnt++;
        if (!ok0 || !ok1 || v1 - v0 != 5)
            $display("FAIL spacing: ok=%b%b pulse distance %0d want 5", ok0, ok1, v1 - v0);
        else pass_cnt++;
        total_cnt++;
        if ({va, done_cnt_o} !== {32'h204, 16'd13})
            $display("FAIL spacing_counts: addr=%h done=%0d want 204 13", va, done_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int p;
        bit seen;
        seen = 1'b0;
        repeat (4) @(negedge clk);
        push(1'b1, 1'b0, 32'h300, 32'hDEAD_0000, p);
        push(1'b1, 1'b0, 32'h304, 32'hDEAD_0001, p);
        push(1'b1, 1'b0, 32'h308, 32'hDEAD_0002, p);
        @(negedge clk);
        total_cnt++;
        if ({cpu_req_addr_o, busy_o, cpu_req_valid_o} !== {32'h300, 1'b1, 1'b0})
            $display("FAIL pre_reset_wait: addr=%h busy=%b valid=%b want 300 1 0",
                     cpu_req_addr_o, busy_o, cpu_req_valid_o);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({cpu_req_valid_o, cpu_req_rw_o, cpu_req_addr_o, cpu_req_data_o, rsp_valid_o,
             rsp_data_o, rsp_err_o, busy_o, done_cnt_o, err_cnt_o, timeout_o} !== '0
            || cmd_ready_o !== 1'b1)
            $display("FAIL async_reset: addr=%h data=%h rsp_data=%h busy=%b done=%0d to=%b ready=%b want 0s ready 1",
                     cpu_req_addr_o, cpu_req_data_o, rsp_data_o, busy_o, done_cnt_o, timeout_o, cmd_ready_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cpu_data_ready_i = 1'b1;
        cpu_data_i       = 32'h77;
        @(negedge clk);
        cpu_data_ready_i = 1'b0;
        cpu_data_i       = '0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid_o || cpu_req_valid_o) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if ({seen, done_cnt_o, busy_o} !== {1'b0, 16'd0, 1'b0})
            $display("FAIL late_ready: activity=%b done=%0d busy=%b want 0 0 0", seen, done_cnt_o, busy_o);
        else pass_cnt++;
    endtask

    initial begin
        mem[32'h4] = 32'h1234;
        test_reset();
        test_write_read();
        test_mismatch();
        test_timeout();
        test_queue_full();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
